// File: rtl/fp_result_checker.sv
// Result checker for the FP unit: a FIFO of expected results is compared against DUT results.
// Optional stop-on-fail behaviour is selected by defining FP_CHECKER_STOP_ON_FAIL_EN.
module fp_result_checker #(
    parameter int XLEN    = 32,
    parameter int EXP_W   = 8,
    parameter int FLAGS_W = 5,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 32
) (
    input  logic                       reset,
    input  logic                       clock,
    input  logic                       clear,
    input  logic                       exp_valid,
    output logic                       exp_ready,
    input  logic [XLEN-1:0]            exp_result,
    input  logic [FLAGS_W-1:0]         exp_flags,
    input  logic                       exp_nanchk,
    input  logic                       dut_valid,
    input  logic [XLEN-1:0]            dut_result,
    input  logic [FLAGS_W-1:0]         dut_flags,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [CNT_W-1:0]           pass_cnt,
    output logic [CNT_W-1:0]           fail_cnt,
    output logic                       fail,
    output logic                       underflow,
    output logic                       overflow,
    output logic [XLEN-1:0]            cap_exp_result,
    output logic [XLEN-1:0]            cap_dut_result,
    output logic [FLAGS_W-1:0]         cap_exp_flags,
    output logic [FLAGS_W-1:0]         cap_dut_flags
);
    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;
    localparam int FW    = XLEN - EXP_W - 1;
    localparam logic [XLEN-1:0] ONES      = '1;
    localparam logic [XLEN-1:0] CANON_NAN = (ONES >> (XLEN - EXP_W - 1)) << (XLEN - EXP_W - 2);

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;
    logic               fail_q, fail_d, underflow_q, underflow_d, overflow_q, overflow_d;
    logic [XLEN-1:0]    cap_exp_result_q, cap_exp_result_d, cap_dut_result_q, cap_dut_result_d;
    logic [FLAGS_W-1:0] cap_exp_flags_q, cap_exp_flags_d, cap_dut_flags_q, cap_dut_flags_d;

    logic [XLEN-1:0]    mem_result_q [DEPTH];
    logic [FLAGS_W-1:0] mem_flags_q  [DEPTH];
    logic               mem_nanchk_q [DEPTH];

    logic               full, empty, stopped, push, pop, ovf_evt, unf_evt;
    logic [XLEN-1:0]    head_result;
    logic [FLAGS_W-1:0] head_flags;
    logic               head_nanchk, exp_is_nan, result_ok, match;

`ifdef FP_CHECKER_STOP_ON_FAIL_EN
    assign stopped = fail_q;
`else
    assign stopped = 1'b0;
`endif

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    // Handshake: an entry transfers on a rising edge where exp_valid && exp_ready; a pop
    // in the same cycle frees the head slot, so a push into a full FIFO is also accepted then.
    assign exp_ready = reset && !full && !stopped;
    assign occupancy = wr_ptr_q - rd_ptr_q;

    assign head_result = mem_result_q[rd_ptr_q[AW-1:0]];
    assign head_flags  = mem_flags_q[rd_ptr_q[AW-1:0]];
    assign head_nanchk = mem_nanchk_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        pop     = dut_valid && !empty && !stopped;
        push    = exp_valid && !stopped && (!full || pop);
        ovf_evt = exp_valid && !stopped && full && !pop;
        unf_evt = dut_valid && !stopped && empty;
        // A canonical qNaN from the DUT accepts any expected NaN on FP-format entries.
        exp_is_nan = (&head_result[XLEN-2 -: EXP_W]) && (|head_result[FW-1:0]);
        result_ok  = (head_nanchk && (dut_result == CANON_NAN)) ? exp_is_nan
                                                               : (head_result == dut_result);
        match      = result_ok && (head_flags == dut_flags);
    end

    always_comb begin
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        pass_cnt_d       = pass_cnt_q;
        fail_cnt_d       = fail_cnt_q;
        fail_d           = fail_q;
        underflow_d      = underflow_q;
        overflow_d       = overflow_q;
        cap_exp_result_d = cap_exp_result_q;
        cap_dut_result_d = cap_dut_result_q;
        cap_exp_flags_d  = cap_exp_flags_q;
        cap_dut_flags_d  = cap_dut_flags_q;
        if (clear) begin
            wr_ptr_d         = '0;
            rd_ptr_d         = '0;
            pass_cnt_d       = '0;
            fail_cnt_d       = '0;
            fail_d           = 1'b0;
            underflow_d      = 1'b0;
            overflow_d       = 1'b0;
            cap_exp_result_d = '0;
            cap_dut_result_d = '0;
            cap_exp_flags_d  = '0;
            cap_dut_flags_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (ovf_evt) overflow_d = 1'b1;
            if (unf_evt) underflow_d = 1'b1;
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                if (match) begin
                    if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + 1'b1;
                end else begin
                    if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + 1'b1;
                    if (!fail_q) begin
                        fail_d           = 1'b1;
                        cap_exp_result_d = head_result;
                        cap_dut_result_d = dut_result;
                        cap_exp_flags_d  = head_flags;
                        cap_dut_flags_d  = dut_flags;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            pass_cnt_q       <= '0;
            fail_cnt_q       <= '0;
            fail_q           <= 1'b0;
            underflow_q      <= 1'b0;
            overflow_q       <= 1'b0;
            cap_exp_result_q <= '0;
            cap_dut_result_q <= '0;
            cap_exp_flags_q  <= '0;
            cap_dut_flags_q  <= '0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            pass_cnt_q       <= pass_cnt_d;
            fail_cnt_q       <= fail_cnt_d;
            fail_q           <= fail_d;
            underflow_q      <= underflow_d;
            overflow_q       <= overflow_d;
            cap_exp_result_q <= cap_exp_result_d;
            cap_dut_result_q <= cap_dut_result_d;
            cap_exp_flags_q  <= cap_exp_flags_d;
            cap_dut_flags_q  <= cap_dut_flags_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_result_q[i] <= '0;
                mem_flags_q[i]  <= '0;
                mem_nanchk_q[i] <= 1'b0;
            end
        end else if (push && !clear) begin
            mem_result_q[wr_ptr_q[AW-1:0]] <= exp_result;
            mem_flags_q[wr_ptr_q[AW-1:0]]  <= exp_flags;
            mem_nanchk_q[wr_ptr_q[AW-1:0]] <= exp_nanchk;
        end
    end

    assign pass_cnt       = pass_cnt_q;
    assign fail_cnt       = fail_cnt_q;
    assign fail           = fail_q;
    assign underflow      = underflow_q;
    assign overflow       = overflow_q;
    assign cap_exp_result = cap_exp_result_q;
    assign cap_dut_result = cap_dut_result_q;
    assign cap_exp_flags  = cap_exp_flags_q;
    assign cap_dut_flags  = cap_dut_flags_q;
endmodule

// File: tb/tb_fp_result_checker.sv
// Self-checking bench for fp_result_checker: directed test-plan steps plus a random phase,
// every cycle compared against a queue-based reference model.
module tb_fp_result_checker;
    localparam int XLEN = 32, EXP_W = 8, FLAGS_W = 5, DEPTH = 8, CNT_W = 32;
    localparam int W = XLEN + FLAGS_W + 1;
`ifdef FP_CHECKER_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic reset, clock, clear, exp_valid, exp_ready, exp_nanchk, dut_valid;
    logic [XLEN-1:0] exp_result, dut_result, cap_exp_result, cap_dut_result;
    logic [FLAGS_W-1:0] exp_flags, dut_flags, cap_exp_flags, cap_dut_flags;
    logic [$clog2(DEPTH):0] occupancy;
    logic [CNT_W-1:0] pass_cnt, fail_cnt;
    logic fail, underflow, overflow;

    fp_result_checker #(.XLEN(XLEN), .EXP_W(EXP_W), .FLAGS_W(FLAGS_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .reset(reset), .clock(clock), .clear(clear),
        .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_result(exp_result),
        .exp_flags(exp_flags), .exp_nanchk(exp_nanchk),
        .dut_valid(dut_valid), .dut_result(dut_result), .dut_flags(dut_flags),
        .occupancy(occupancy), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .fail(fail),
        .underflow(underflow), .overflow(overflow),
        .cap_exp_result(cap_exp_result), .cap_dut_result(cap_dut_result),
        .cap_exp_flags(cap_exp_flags), .cap_dut_flags(cap_dut_flags)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // reference model: scoreboard queue of {result, flags, nanchk}
    logic [W-1:0] exp_q[$];
    int unsigned m_pass, m_fail_cnt;
    bit m_fail, m_unf, m_ovf;
    logic [XLEN-1:0] m_cer, m_cdr;
    logic [FLAGS_W-1:0] m_cef, m_cdf;
    int checks = 0, errors = 0;

    function automatic bit is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 0);
    endfunction

    function automatic bit entry_matches(input logic [W-1:0] e, input logic [31:0] r, input logic [4:0] f);
        logic [31:0] er;
        logic [4:0] ef;
        er = e[W-1 -: XLEN];
        ef = e[FLAGS_W:1];
        if (ef != f) return 1'b0;
        if (e[0] && r == 32'h7FC00000) return is_nan(er);
        return er == r;
    endfunction

    task automatic model_zero();
        exp_q.delete();
        m_pass = 0; m_fail_cnt = 0; m_fail = 0; m_unf = 0; m_ovf = 0;
        m_cer = '0; m_cdr = '0; m_cef = '0; m_cdf = '0;
    endtask

    task automatic model_update();
        bit stopped, do_pop, do_push, was_full;
        logic [W-1:0] head;
        if (!reset || clear) begin
            model_zero();
            return;
        end
        stopped  = STOP && m_fail;
        was_full = (exp_q.size() == DEPTH);
        do_pop   = dut_valid && exp_q.size() > 0 && !stopped;
        do_push  = exp_valid && !stopped && (!was_full || do_pop);
        if (exp_valid && !stopped && was_full && !do_pop) m_ovf = 1;
        if (dut_valid && !stopped && exp_q.size() == 0) m_unf = 1;
        if (do_pop) begin
            head = exp_q.pop_front();
            if (entry_matches(head, dut_result, dut_flags)) begin
                if (m_pass != 32'hFFFFFFFF) m_pass++;
            end else begin
                if (m_fail_cnt != 32'hFFFFFFFF) m_fail_cnt++;
                if (!m_fail) begin
                    m_fail = 1;
                    m_cer = head[W-1 -: XLEN]; m_cef = head[FLAGS_W:1];
                    m_cdr = dut_result; m_cdf = dut_flags;
                end
            end
        end
        if (do_push) exp_q.push_back({exp_result, exp_flags, exp_nanchk});
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, want);
        end
    endtask

    task automatic check_all();
        chk("occupancy", 64'(occupancy), 64'(exp_q.size()));
        chk("exp_ready", 64'(exp_ready), 64'(reset && exp_q.size() < DEPTH && !(STOP && m_fail)));
        chk("pass_cnt", 64'(pass_cnt), 64'(m_pass));
        chk("fail_cnt", 64'(fail_cnt), 64'(m_fail_cnt));
        chk("fail", 64'(fail), 64'(m_fail));
        chk("underflow", 64'(underflow), 64'(m_unf));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("cap_exp_result", 64'(cap_exp_result), 64'(m_cer));
        chk("cap_dut_result", 64'(cap_dut_result), 64'(m_cdr));
        chk("cap_exp_flags", 64'(cap_exp_flags), 64'(m_cef));
        chk("cap_dut_flags", 64'(cap_dut_flags), 64'(m_cdf));
    endtask

    // driver tasks
    task automatic step();
        @(posedge clock);
        model_update();
        #1;
        check_all();
    endtask

    task automatic cyc(input logic ev, input logic [31:0] er, input logic [4:0] ef, input logic en,
                       input logic dv, input logic [31:0] dr, input logic [4:0] df);
        exp_valid = ev; exp_result = er; exp_flags = ef; exp_nanchk = en;
        dut_valid = dv; dut_result = dr; dut_flags = df;
        step();
        exp_valid = 0; dut_valid = 0;
    endtask

    task automatic push(input logic [31:0] r, input logic [4:0] f, input logic n);
        cyc(1, r, f, n, 0, 0, 0);
    endtask

    task automatic pop(input logic [31:0] r, input logic [4:0] f);
        cyc(0, 0, 0, 0, 1, r, f);
    endtask

    task automatic do_clear();
        clear = 1;
        cyc(0, 0, 0, 0, 0, 0, 0);
        clear = 0;
    endtask

    function automatic logic [31:0] pick_value();
        case ($urandom_range(0, 6))
            0: return 32'h3F800000;
            1: return 32'h40000000;
            2: return 32'h7FC00000;
            3: return 32'hFFC00001;
            4: return 32'h7F800001;
            5: return 32'h7F800000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [W-1:0] h;
        logic [31:0] dr;
        logic [4:0] df;
        reset = 0; clear = 0; exp_valid = 0; dut_valid = 0;
        exp_result = 0; exp_flags = 0; exp_nanchk = 0; dut_result = 0; dut_flags = 0;
        model_zero();
        step();
        step();
        chk("reset_ready", 64'(exp_ready), 64'd0);
        chk("reset_occ", 64'(occupancy), 64'd0);
        reset = 1;
        #1;
        chk("ready_after_reset", 64'(exp_ready), 64'd1);

        // three matching results, the last via canonical NaN
        push(32'h3F800000, 5'h00, 0);
        push(32'h40000000, 5'h01, 0);
        push(32'h7FC00000, 5'h10, 1);
        pop(32'h3F800000, 5'h00);
        pop(32'h40000000, 5'h01);
        pop(32'h7FC00000, 5'h10);
        chk("tp1_pass", 64'(pass_cnt), 64'd3);
        chk("tp1_fail_cnt", 64'(fail_cnt), 64'd0);
        chk("tp1_fail", 64'(fail), 64'd0);
        chk("tp1_occ", 64'(occupancy), 64'd0);

        // NaN relaxation on and off
        do_clear();
        push(32'hFFC00001, 5'h00, 1);
        pop(32'h7FC00000, 5'h00);
        chk("tp2_nan_pass", 64'(pass_cnt), 64'd1);
        push(32'hFFC00001, 5'h00, 0);
        pop(32'h7FC00000, 5'h00);
        chk("tp2_fail", 64'(fail), 64'd1);
        chk("tp2_cap_exp", 64'(cap_exp_result), 64'hFFC00001);
        chk("tp2_cap_dut", 64'(cap_dut_result), 64'h7FC00000);

        // flag mismatch then a second mismatch
        do_clear();
        push(32'h3F800000, 5'h01, 0);
        push(32'h40000000, 5'h00, 0);
        pop(32'h3F800000, 5'h00);
        pop(32'h40400000, 5'h00);
`ifndef FP_CHECKER_STOP_ON_FAIL_EN
        chk("tp3_fail_cnt", 64'(fail_cnt), 64'd2);
`endif
        chk("tp3_cap_ef", 64'(cap_exp_flags), 64'h01);
        chk("tp3_cap_df", 64'(cap_dut_flags), 64'h00);
        chk("tp3_cap_er", 64'(cap_exp_result), 64'h3F800000);
        chk("tp3_cap_dr", 64'(cap_dut_result), 64'h3F800000);

        // fill, push+pop while full, then overflow
        do_clear();
        for (int i = 0; i < DEPTH; i++) push(32'(i), 5'h00, 0);
        chk("tp4_full_ready", 64'(exp_ready), 64'd0);
        cyc(1, 32'h100, 5'h00, 0, 1, 32'h0, 5'h00);
        chk("tp4_pp_occ", 64'(occupancy), 64'd8);
        chk("tp4_pp_ovf", 64'(overflow), 64'd0);
        push(32'h200, 5'h00, 0);
        chk("tp4_ovf", 64'(overflow), 64'd1);
        chk("tp4_occ", 64'(occupancy), 64'd8);

        // underflow with simultaneous push, then clear
        do_clear();
        cyc(1, 32'h5, 5'h00, 0, 1, 32'h5, 5'h00);
        chk("tp5_unf", 64'(underflow), 64'd1);
        chk("tp5_occ", 64'(occupancy), 64'd1);
        chk("tp5_pass", 64'(pass_cnt), 64'd0);
        chk("tp5_fail_cnt", 64'(fail_cnt), 64'd0);
        do_clear();
        chk("tp5_clr_unf", 64'(underflow), 64'd0);
        chk("tp5_clr_occ", 64'(occupancy), 64'd0);
        chk("tp5_clr_ready", 64'(exp_ready), 64'd1);

`ifdef FP_CHECKER_STOP_ON_FAIL_EN
        push(32'h1, 5'h00, 0);
        push(32'h2, 5'h00, 0);
        pop(32'h9, 5'h00);
        for (int i = 0; i < 4; i++) pop(32'h2, 5'h00);
        push(32'h3, 5'h00, 0);
        chk("tp6_fail_cnt", 64'(fail_cnt), 64'd1);
        chk("tp6_occ", 64'(occupancy), 64'd1);
        chk("tp6_ready", 64'(exp_ready), 64'd0);
        chk("tp6_ovf", 64'(overflow), 64'd0);
        do_clear();
        chk("tp6_clr_ready", 64'(exp_ready), 64'd1);
`endif

        // reset mid-stream loses queued entries
        push(32'hA, 5'h00, 0);
        push(32'hB, 5'h00, 0);
        reset = 0;
        cyc(1, 32'hC, 5'h00, 0, 1, 32'hA, 5'h00);
        reset = 1;
        chk("tp7_occ", 64'(occupancy), 64'd0);
        chk("tp7_pass", 64'(pass_cnt), 64'd0);

        // random phase
        for (int n = 0; n < 600; n++) begin
            clear = ($urandom_range(0, 63) == 0);
            if (exp_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                h  = exp_q[0];
                dr = h[W-1 -: XLEN];
                df = h[FLAGS_W:1];
                if (h[0] && is_nan(dr) && $urandom_range(0, 1) == 1) dr = 32'h7FC00000;
            end else begin
                dr = pick_value();
                df = 5'($urandom_range(0, 3));
            end
            cyc(1'($urandom_range(0, 1)), pick_value(), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), dr, df);
            clear = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
